// File: rtl/if_id_pkg.sv
// if_id_pkg: instruction field helpers, opcodes and FSM/EX-shadow types for if_id_ctrl.
package if_id_pkg;
   localparam logic [5:0] OP_R     = 6'h00;
   localparam logic [5:0] OP_LOAD  = 6'h23;
   localparam logic [5:0] OP_STORE = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_JMP   = 6'h02;
   localparam logic [31:0] NOP     = 32'h0;

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

   // Only the fields the hazard check needs are kept for the instruction in EX.
   typedef struct packed {
      logic       valid;
      logic [5:0] op;
      logic [4:0] rd;
   } ex_t;

   function automatic logic [5:0] op_f(input logic [31:0] i);
      return i[31:26];
   endfunction

   function automatic logic [4:0] rd_f(input logic [31:0] i);
      return i[25:21];
   endfunction

   function automatic logic [4:0] rs1_f(input logic [31:0] i);
      return i[20:16];
   endfunction

   function automatic logic [4:0] rs2_f(input logic [31:0] i);
      return i[15:11];
   endfunction

   function automatic logic uses_rs2(input logic [5:0] op);
      return op == OP_R || op == OP_STORE || op == OP_BEQ || op == OP_BNE;
   endfunction
endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: flags a load in EX whose destination is read by the instruction in ID.
module hazard_unit
   import if_id_pkg::*;
(
   input  ex_t        ex,
   input  logic [5:0] id_op,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_valid,
   output logic       hazard
);
   assign hazard = ex.valid && ex.op == OP_LOAD && ex.rd != 5'd0 && id_valid &&
                   (id_rs1 == ex.rd || (uses_rs2(id_op) && id_rs2 == ex.rd));
endmodule

// File: rtl/if_id_ctrl.sv
// if_id_ctrl: IF/ID register, branch resolve, load-use stall and wrong-path squash.
// Define IF_STATS_EN to add the brCount/stallCount event counters.
module if_id_ctrl
   import if_id_pkg::*;
#(
   parameter int LOAD_STALL  = 1,
   parameter int FLUSH_SLOTS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC,
   input  logic [31:0] instruction,
   input  logic [31:0] rs1Val,
   input  logic [31:0] rs2Val,
   output logic        brTaken,
   output logic [31:0] brOffset,
   output logic        freeze,
   output logic [31:0] idPC,
   output logic [31:0] idInstr,
   output logic        idValid,
   output logic        issueValid
`ifdef IF_STATS_EN
   ,
   output logic [31:0] brCount,
   output logic [31:0] stallCount
`endif
);
   state_t      state, state_n;
   logic [15:0] cnt, cnt_n;
   ex_t         ex;
   logic        hazard, taken;
   logic [5:0]  op;
   logic [31:0] off;

   assign op = op_f(idInstr);

   hazard_unit u_hazard (
      .ex      (ex),
      .id_op   (op),
      .id_rs1  (rs1_f(idInstr)),
      .id_rs2  (rs2_f(idInstr)),
      .id_valid(idValid),
      .hazard  (hazard)
   );

   always_comb begin
      taken      = op == OP_BEQ ? rs1Val == rs2Val : op == OP_BNE ? rs1Val != rs2Val : op == OP_JMP;
      off        = op == OP_JMP ? {{4{idInstr[25]}}, idInstr[25:0], 2'b00}
                                : {{14{idInstr[15]}}, idInstr[15:0], 2'b00};
      freeze     = state == STALL || (state == RUN && hazard);
      brTaken    = state == RUN && !hazard && idValid && taken;
      brOffset   = brTaken ? off : 32'h0;
      issueValid = !freeze && idValid;
      state_n    = state;
      cnt_n      = cnt;
      if (state == RUN && hazard) begin
         state_n = LOAD_STALL > 1 ? STALL : RUN;
         cnt_n   = 16'(LOAD_STALL - 2);
      end else if (brTaken) begin
         state_n = FLUSH_SLOTS > 1 ? FLUSH : RUN;
         cnt_n   = 16'(FLUSH_SLOTS - 2);
      end else if (state != RUN) begin
         state_n = cnt == 16'd0 ? RUN : state;
         cnt_n   = cnt == 16'd0 ? cnt : cnt - 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RUN;
         cnt     <= '0;
         ex      <= '0;
         idPC    <= '0;
         idInstr <= NOP;
         idValid <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         ex    <= issueValid ? '{valid: 1'b1, op: op, rd: rd_f(idInstr)} : '0;
         if (!freeze) begin
            idPC    <= PC;
            idInstr <= brTaken || state == FLUSH ? NOP : instruction;
            idValid <= !(brTaken || state == FLUSH);
         end
      end
   end

`ifdef IF_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         brCount    <= '0;
         stallCount <= '0;
      end else begin
         brCount    <= brCount + 32'(brTaken);
         stallCount <= stallCount + 32'(freeze);
      end
   end
`endif
endmodule

// File: tb/tb_if_id_ctrl.sv
// tb_if_id_ctrl: directed and random stimulus against a slot/countdown reference model.
module tb_if_id_ctrl;
   localparam int LS = 3;
   localparam int FS = 2;
   localparam logic [5:0] R = 6'h00, LD = 6'h23, ST = 6'h2B, BEQ = 6'h04, BNE = 6'h05, JMP = 6'h02;

   logic clk = 1'b0, rst = 1'b1;
   logic [31:0] PC = 0, instruction = 0, rs1Val = 0, rs2Val = 0;
   logic        brTaken, freeze, idValid, issueValid;
   logic [31:0] brOffset, idPC, idInstr;
`ifdef IF_STATS_EN
   logic [31:0] brCount, stallCount;
`endif

   if_id_ctrl #(.LOAD_STALL(LS), .FLUSH_SLOTS(FS)) dut (
      .clk(clk), .rst(rst), .PC(PC), .instruction(instruction), .rs1Val(rs1Val), .rs2Val(rs2Val),
      .brTaken(brTaken), .brOffset(brOffset), .freeze(freeze), .idPC(idPC), .idInstr(idInstr),
      .idValid(idValid), .issueValid(issueValid)
`ifdef IF_STATS_EN
      , .brCount(brCount), .stallCount(stallCount)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0, passed = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Reference model: ID and EX slots plus remaining-freeze and remaining-squash counts.
   logic [31:0] m_id_pc, m_id_in, m_ex_in, m_brc, m_stc;
   logic        m_id_v, m_ex_v;
   int          m_stall, m_flush;
   logic        e_fr, e_br, e_iss, hz, tk;
   logic [31:0] e_off;
   logic        o_fr, o_br, o_iss, o_idv;
   logic [31:0] o_off, o_idi, o_pc;

   task automatic model_reset();
      m_id_pc = 0; m_id_in = 0; m_id_v = 0; m_ex_in = 0; m_ex_v = 0;
      m_stall = 0; m_flush = 0; m_brc = 0; m_stc = 0;
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [15:0] imm);
      return {op, rd, rs1, imm};
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [5:0] ops [7] = '{R, LD, ST, BEQ, BNE, JMP, 6'h0F};
      return {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
              5'($urandom_range(0, 4)), 11'($urandom)};
   endfunction

   task automatic cyc(input logic [31:0] p, input logic [31:0] i, input logic [31:0] a,
                      input logic [31:0] b, input logic r);
      logic [5:0] iop;
      PC = p; instruction = i; rs1Val = a; rs2Val = b; rst = r;
      @(negedge clk);
      iop   = m_id_in[31:26];
      hz    = m_ex_v && m_ex_in[31:26] == LD && m_ex_in[25:21] != 0 && m_id_v &&
              (m_id_in[20:16] == m_ex_in[25:21] ||
               ((iop == R || iop == ST || iop == BEQ || iop == BNE) && m_id_in[15:11] == m_ex_in[25:21]));
      tk    = (iop == BEQ && a == b) || (iop == BNE && a != b) || iop == JMP;
      e_fr  = m_stall > 0 || hz;
      e_br  = !e_fr && m_id_v && m_flush == 0 && tk;
      e_iss = !e_fr && m_id_v;
      e_off = !e_br ? 32'h0 : iop == JMP ? 32'($signed(m_id_in[25:0])) * 4 : 32'($signed(m_id_in[15:0])) * 4;
      o_fr = freeze; o_br = brTaken; o_iss = issueValid; o_idv = idValid;
      o_off = brOffset; o_idi = idInstr; o_pc = idPC;
      chk("freeze", freeze, e_fr);
      chk("brTaken", brTaken, e_br);
      chk("brOffset", brOffset, e_off);
      chk("issueValid", issueValid, e_iss);
      chk("idValid", idValid, m_id_v);
      chk("idInstr", idInstr, m_id_in);
      chk("excl", freeze & brTaken, 0);
      if (m_id_v) chk("idPC", idPC, m_id_pc);
`ifdef IF_STATS_EN
      chk("brCount", brCount, m_brc);
      chk("stallCount", stallCount, m_stc);
`endif
      @(posedge clk);
      if (r) model_reset();
      else begin
         m_brc += 32'(e_br);
         m_stc += 32'(e_fr);
         m_ex_v  = e_iss;
         m_ex_in = e_iss ? m_id_in : 0;
         if (m_stall > 0) m_stall--;
         else if (hz) m_stall = LS - 1;
         if (!e_fr) begin
            m_id_pc = p;
            m_id_v  = !(e_br || m_flush > 0);
            m_id_in = m_id_v ? i : 0;
         end
         if (e_br) m_flush = FS - 1;
         else if (m_flush > 0) m_flush--;
      end
      #1;
   endtask

   initial begin
      int nf, nb;
      logic [31:0] rp, ri;
      model_reset();
      rst = 1;
      @(posedge clk);
      #1;
      // reset state and first capture
      cyc(0, mk(R, 1, 2, 16'h2800), 0, 0, 0);
      chk("rst_idValid", o_idv, 0);
      chk("rst_brTaken", o_br, 0);
      chk("rst_freeze", o_fr, 0);
      cyc(4, 0, 0, 0, 0);
      chk("first_pc", o_pc, 0);
      // BEQ taken
      cyc(16, mk(BEQ, 0, 1, 16'h0004), 0, 0, 0);
      cyc(20, 0, 5, 5, 0);
      chk("beq_taken", o_br, 1);
      chk("beq_off", o_off, 32'h10);
      cyc(24, 0, 0, 0, 0);
      chk("beq_squash_v", o_idv, 0);
      chk("beq_squash_i", o_idi, 0);
      cyc(28, 0, 0, 0, 0);
      // BNE not taken, then taken with negative offset
      cyc(32, mk(BNE, 0, 1, 16'hFFFE), 0, 0, 0);
      cyc(36, 0, 7, 7, 0);
      chk("bne_nt", o_br, 0);
      cyc(40, mk(BNE, 0, 1, 16'hFFFE), 0, 0, 0);
      cyc(44, 0, 7, 8, 0);
      chk("bne_off", o_off, 32'hFFFF_FFF8);
      cyc(48, 0, 0, 0, 0);
      cyc(52, 0, 0, 0, 0);
      // load-use stall length
      cyc(56, mk(LD, 3, 1, 0), 0, 0, 0);
      cyc(60, mk(R, 1, 2, 16'h1800), 0, 0, 0);
      nf = 0;
      for (int k = 0; k < 6; k++) begin
         cyc(64, 0, 0, 0, 0);
         nf += int'(o_fr);
         if (o_fr) chk("stall_issue", o_iss, 0);
      end
      chk("stall_len", nf, LS);
      cyc(68, mk(LD, 0, 1, 0), 0, 0, 0);
      cyc(72, mk(R, 1, 0, 0), 0, 0, 0);
      cyc(76, 0, 0, 0, 0);
      chk("ld_rd0", o_fr, 0);
      // hazard beats branch, branch resolves afterwards
      cyc(80, mk(LD, 4, 1, 0), 0, 0, 0);
      cyc(84, mk(BEQ, 0, 4, 16'h0008), 9, 9, 0);
      nf = 0; nb = 0;
      for (int k = 0; k < 7; k++) begin
         cyc(88, 0, 9, 9, 0);
         nf += int'(o_fr);
         nb += int'(o_br);
      end
      chk("hb_stalls", nf, LS);
      chk("hb_branches", nb, 1);
      // reset during STALL
      cyc(92, mk(LD, 3, 1, 0), 0, 0, 0);
      cyc(96, mk(R, 1, 3, 0), 0, 0, 0);
      cyc(100, 0, 0, 0, 0);
      cyc(104, 0, 0, 0, 1);
      chk("mid_stall_fr", o_fr, 1);
      cyc(0, 0, 0, 0, 0);
      chk("rst_stall_fr", o_fr, 0);
      chk("rst_stall_v", o_idv, 0);
`ifdef IF_STATS_EN
      chk("rst_brCount", brCount, 0);
      chk("rst_stallCount", stallCount, 0);
`endif
      // random traffic; IF holds its PC and instruction while frozen
      rp = 4; ri = rnd_instr();
      for (int k = 0; k < 500; k++) begin
         cyc(rp, ri, 32'($urandom_range(0, 2)), 32'($urandom_range(0, 2)), 0);
         if (!e_fr) begin
            rp = e_br ? rp + e_off : rp + 4;
            ri = rnd_instr();
         end
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
